flippy_game_engine: RTL and testbench

//  Parametrised game core for Flippy Bit: NUM_COLS falling-byte columns, shared LFSR letter source,

---
 rtl/flippy_game_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_flippy_game_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flippy_game_engine.sv
// flippy_game_engine
//   Game core for Flippy Bit. NUM_COLS columns each carry a falling letter.
//   The letters come from one shared 16-bit Galois LFSR. A fall timer steps
//   the columns and speeds up as the score rises. An IDLE/PLAY/OVER state
//   machine handles matching, scoring and game over.
// Ports
//   clock        : only clock
//   reset_signal : synchronous, active-high reset; wins over every other input
//   start        : start/restart pulse; honoured in IDLE and OVER only
//   user_input   : player switch value compared against column letters
//   submit       : compare strobe, only consulted when MATCH_MODE = 1
//   ypos         : column i row at [i*YPOS_W +: YPOS_W]
//   letter       : column i letter at [i*DATA_W +: DATA_W]
//   col_active   : column i is falling and visible
//   correct      : one-cycle pulse per cleared column
//   score        : saturating point count
//   level        : speed level, min(score / SPEEDUP, MAX_LEVEL)
//   game_over    : high while in OVER
module flippy_game_engine #(
    parameter int          NUM_COLS   = 3,
    parameter int          DATA_W     = 8,
    parameter int          ROWS       = 30,
    parameter int          YPOS_W     = 5,
    parameter int          TICK_DIV   = 25000000,
    parameter int          SPAWN_GAP  = 4,
    parameter int          SPEEDUP    = 8,
    parameter int          MAX_LEVEL  = 5,
    parameter int          SCORE_W    = 8,
    parameter int          MATCH_MODE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         reset_signal,
    input  logic                         start,
    input  logic [DATA_W-1:0]            user_input,
    input  logic                         submit,
    output logic [NUM_COLS*YPOS_W-1:0]   ypos,
    output logic [NUM_COLS*DATA_W-1:0]   letter,
    output logic [NUM_COLS-1:0]          col_active,
    output logic [NUM_COLS-1:0]          correct,
    output logic [SCORE_W-1:0]           score,
    output logic [2:0]                   level,
    output logic                         game_over
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

    localparam int CD_W = 16;

    // One Galois step for x^16 + x^14 + x^13 + x^11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Low DATA_W bits of v rotated left by 3*col, nudged off the current input
    function automatic logic [DATA_W-1:0] spawn_value(input logic [15:0] v, input int col,
                                                      input logic [DATA_W-1:0] u);
        logic [DATA_W-1:0] r;
        int sh;
        sh = (3 * col) % 16;
        for (int b = 0; b < DATA_W; b++) begin
            r[b] = v[4'((b + 16 - sh) % 16)];
        end
        if (r == u) begin
            r = r + DATA_W'(1);
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Speed level reached by a given score
    function automatic logic [2:0] level_of(input logic [SCORE_W-1:0] s);
        int q;
        q = int'(s) / SPEEDUP;
        if (q > MAX_LEVEL) begin
            q = MAX_LEVEL;
        end else begin
            q = q;
        end
        return 3'(q);
    endfunction

    // Fall step period; never below one cycle even when the shift empties TICK_DIV
    function automatic logic [31:0] period_of(input logic [2:0] lvl);
        int p;
        p = TICK_DIV >> lvl;
        if (p < 1) begin
            p = 1;
        end else begin
            p = p;
        end
        return 32'(p);
    endfunction

    // Number of set bits in a column mask
    function automatic logic [3:0] popcount(input logic [NUM_COLS-1:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_COLS; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

    state_t                state_r;
    logic [15:0]           lfsr_r;
    logic [31:0]           tick_cnt_r;
    logic [2:0]            level_r;
    logic [SCORE_W-1:0]    score_r;
    logic [NUM_COLS-1:0]   col_active_r;
    logic [NUM_COLS-1:0]   correct_r;
    logic                  game_over_r;
    logic [YPOS_W-1:0]     ypos_r   [NUM_COLS];
    logic [DATA_W-1:0]     letter_r [NUM_COLS];
    logic [CD_W-1:0]       cd_r     [NUM_COLS];

    logic [31:0]           period_s;
    logic                  tick_s;
    logic [2:0]            level_next_s;
    logic                  start_game_s;
    logic [NUM_COLS-1:0]   match_s;
    logic                  miss_s;
    logic [SCORE_W:0]      sum_s;
    logic [SCORE_W-1:0]    score_next_s;
    logic [DATA_W-1:0]     spawn_letter_s [NUM_COLS];

    // Fall timer tick, next level and fresh-game request
    always_comb begin
        period_s     = period_of(level_r);
        tick_s       = (state_r == S_PLAY) && (tick_cnt_r == (period_s - 32'd1));
        level_next_s = level_of(score_r);
        start_game_s = start && (state_r != S_PLAY);
    end

    // Per-column match and bottom-row miss; a matching column can never miss
    always_comb begin
        match_s = '0;
        miss_s  = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if ((state_r == S_PLAY) && col_active_r[i] && (letter_r[i] == user_input) &&
                ((MATCH_MODE == 0) || submit)) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
            if (tick_s && col_active_r[i] && !match_s[i] &&
                (ypos_r[i] == YPOS_W'(ROWS - 1))) begin
                miss_s = 1'b1;
            end else begin
                miss_s = miss_s;
            end
        end
    end

    // Saturating score after this cycle's clears
    always_comb begin
        sum_s = {1'b0, score_r} + (SCORE_W + 1)'(popcount(match_s));
        if (sum_s[SCORE_W]) begin
            score_next_s = '1;
        end else begin
            score_next_s = sum_s[SCORE_W-1:0];
        end
    end

    // Letter each column would take if it spawned this cycle
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            spawn_letter_s[i] = spawn_value(lfsr_r, i, user_input);
        end
    end

    // Game state machine, column motion, scoring and LFSR
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_r      <= S_IDLE;
            lfsr_r       <= LFSR_SEED;
            tick_cnt_r   <= 32'd0;
            level_r      <= 3'd0;
            score_r      <= '0;
            col_active_r <= '0;
            correct_r    <= '0;
            game_over_r  <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                ypos_r[i]   <= '0;
                letter_r[i] <= '0;
                cd_r[i]     <= '0;
            end
        end else if (start_game_s) begin
            state_r     <= S_PLAY;
            tick_cnt_r  <= 32'd0;
            level_r     <= 3'd0;
            score_r     <= '0;
            correct_r   <= '0;
            game_over_r <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                ypos_r[i] <= '0;
                if ((i * SPAWN_GAP) == 0) begin
                    col_active_r[i] <= 1'b1;
                    letter_r[i]     <= spawn_letter_s[i];
                    cd_r[i]         <= '0;
                end else begin
                    col_active_r[i] <= 1'b0;
                    letter_r[i]     <= '0;
                    cd_r[i]         <= CD_W'(i * SPAWN_GAP);
                end
            end
        end else begin
            case (state_r)
                S_PLAY: begin
                    lfsr_r  <= lfsr_step(lfsr_r);
                    level_r <= level_next_s;
                    if (level_next_s != level_r) begin
                        tick_cnt_r <= 32'd0;
                    end else if (tick_s) begin
                        tick_cnt_r <= 32'd0;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + 32'd1;
                    end
                    if (miss_s) begin
                        // Board freezes exactly as it stood before the fatal tick
                        state_r     <= S_OVER;
                        game_over_r <= 1'b1;
                        correct_r   <= '0;
                    end else begin
                        correct_r <= match_s;
                        score_r   <= score_next_s;
                        for (int i = 0; i < NUM_COLS; i++) begin
                            if (match_s[i]) begin
                                col_active_r[i] <= 1'b0;
                                ypos_r[i]       <= '0;
                                cd_r[i]         <= CD_W'(SPAWN_GAP);
                            end else if (tick_s) begin
                                if (col_active_r[i]) begin
                                    ypos_r[i] <= ypos_r[i] + YPOS_W'(1);
                                end else if (cd_r[i] <= CD_W'(1)) begin
                                    col_active_r[i] <= 1'b1;
                                    ypos_r[i]       <= '0;
                                    letter_r[i]     <= spawn_letter_s[i];
                                    cd_r[i]         <= '0;
                                end else begin
                                    cd_r[i] <= cd_r[i] - CD_W'(1);
                                end
                            end else begin
                                cd_r[i] <= cd_r[i];
                            end
                        end
                    end
                end
                S_OVER: begin
                    correct_r   <= '0;
                    game_over_r <= 1'b1;
                end
                S_IDLE: begin
                    correct_r   <= '0;
                    game_over_r <= 1'b0;
                end
                default: begin
                    state_r     <= S_IDLE;
                    correct_r   <= '0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    // Pack per-column registers onto the flat output buses
    always_comb begin
        ypos   = '0;
        letter = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            ypos[i*YPOS_W +: YPOS_W]   = ypos_r[i];
            letter[i*DATA_W +: DATA_W] = letter_r[i];
        end
    end

    assign col_active = col_active_r;
    assign correct    = correct_r;
    assign score      = score_r;
    assign level      = level_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_flippy_game_engine.sv
// Self-checking bench for flippy_game_engine.
// dut0: continuous compare, 8-bit letters. dut1: submit-gated compare, 2-bit
// letters so that two columns sharing a letter happens often.
module tb_flippy_game_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst0, start0, submit0;
    logic [7:0]  ui0;
    logic [14:0] ypos0;
    logic [23:0] letter0;
    logic [2:0]  act0, cor0, lvl0;
    logic [7:0]  score0;
    logic        go0;

    logic        rst1, start1, submit1;
    logic [1:0]  ui1;
    logic [14:0] ypos1;
    logic [5:0]  letter1;
    logic [2:0]  act1, cor1, lvl1;
    logic [7:0]  score1;
    logic        go1;

    flippy_game_engine #(
        .NUM_COLS(3), .DATA_W(8), .ROWS(30), .YPOS_W(5), .TICK_DIV(16), .SPAWN_GAP(4),
        .SPEEDUP(8), .MAX_LEVEL(5), .SCORE_W(8), .MATCH_MODE(0), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clock(clock), .reset_signal(rst0), .start(start0), .user_input(ui0), .submit(submit0),
        .ypos(ypos0), .letter(letter0), .col_active(act0), .correct(cor0), .score(score0),
        .level(lvl0), .game_over(go0)
    );

    flippy_game_engine #(
        .NUM_COLS(3), .DATA_W(2), .ROWS(30), .YPOS_W(5), .TICK_DIV(16), .SPAWN_GAP(4),
        .SPEEDUP(8), .MAX_LEVEL(5), .SCORE_W(8), .MATCH_MODE(1), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clock(clock), .reset_signal(rst1), .start(start1), .user_input(ui1), .submit(submit1),
        .ypos(ypos1), .letter(letter1), .col_active(act1), .correct(cor1), .score(score1),
        .level(lvl1), .game_over(go1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int pc(input logic [2:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]);
    endfunction

    function automatic int lvl_of(input int s);
        return (s / 8 > 5) ? 5 : s / 8;
    endfunction

    // Hard stop in case anything hangs
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] l0;
        logic [2:0] mask;
        int exp_score, prev_score, sat_clears, pick, col, c1, c2, found;
        logic [4:0] yp;
        logic [7:0] v;
        logic [1:0] v1;
        logic hit;

        rst0 = 1'b1; start0 = 1'b0; ui0 = 8'h00; submit0 = 1'b0;
        rst1 = 1'b1; start1 = 1'b0; ui1 = 2'd0; submit1 = 1'b0;
        step(); step();
        check("rst_act", 32'(act0), 32'd0);
        check("rst_ypos", 32'(ypos0), 32'd0);
        check("rst_letter", 32'(letter0), 32'd0);
        check("rst_score", 32'(score0), 32'd0);
        check("rst_level", 32'(lvl0), 32'd0);
        check("rst_go", 32'(go0), 32'd0);
        rst0 = 1'b0;
        step();
        check("idle_act", 32'(act0), 32'd0);

        // Test 1: spawn timing and fall rate
        start0 = 1'b1; step(); start0 = 1'b0;
        check("p0_act", 32'(act0), 32'd1);
        check("p0_y0", 32'(ypos0[4:0]), 32'd0);
        check("p0_l0", 32'(letter0[7:0]), 32'hE1);
        for (int p = 1; p <= 130; p++) begin
            start0 = (p == 100) ? 1'b1 : 1'b0;  // start while playing must be ignored
            step();
            if (p == 15)  check("p15_y0", 32'(ypos0[4:0]), 32'd0);
            if (p == 16)  check("p16_y0", 32'(ypos0[4:0]), 32'd1);
            if (p == 63)  check("p63_act", 32'(act0), 32'b001);
            if (p == 64)  check("p64_act", 32'(act0), 32'b011);
            if (p == 64)  check("p64_y0", 32'(ypos0[4:0]), 32'd4);
            if (p == 127) check("p127_act", 32'(act0), 32'b011);
            if (p == 128) check("p128_act", 32'(act0), 32'b111);
            if (p == 128) check("p128_y0", 32'(ypos0[4:0]), 32'd8);
            if (p == 128) check("p128_score", 32'(score0), 32'd0);
        end
        start0 = 1'b0;

        // Test 2: clear column 0 at p=130, respawn four ticks later
        l0 = letter0[7:0];
        mask = 3'b000;
        for (int i = 0; i < 3; i++) if (act0[i] && letter0[i*8 +: 8] == l0) mask[i] = 1'b1;
        ui0 = l0;
        step();
        check("clr_cor", 32'(cor0), 32'(mask));
        check("clr_score", 32'(score0), 32'(pc(mask)));
        check("clr_act0", 32'(act0[0]), 32'd0);
        step();
        check("clr_cor_pulse", 32'(cor0), 32'd0);
        for (int p = 133; p <= 192; p++) begin
            step();
            if (p == 191) check("respawn_early", 32'(act0[0]), 32'd0);
            if (p == 192) check("respawn_act0", 32'(act0[0]), 32'd1);
            if (p == 192) check("respawn_diff", 32'(letter0[7:0] != l0), 32'd1);
            if (p == 192) check("respawn_y0", 32'(ypos0[4:0]), 32'd0);
        end

        // Reset mid-fall
        rst0 = 1'b1; step(); rst0 = 1'b0;
        check("mid_rst_act", 32'(act0), 32'd0);
        check("mid_rst_ypos", 32'(ypos0), 32'd0);
        check("mid_rst_letter", 32'(letter0), 32'd0);
        check("mid_rst_score", 32'(score0), 32'd0);
        step();

        // Test 4: never match, col0 misses at the bottom
        ui0 = 8'h00;
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int p = 1; p <= 480; p++) begin
            step();
            if (p == 479) check("p479_go", 32'(go0), 32'd0);
            if (p == 479) check("p479_y0", 32'(ypos0[4:0]), 32'd29);
            if (p == 480) check("p480_go", 32'(go0), 32'd1);
            if (p == 480) check("p480_y0", 32'(ypos0[4:0]), 32'd29);
        end
        ui0 = 8'hE1;  // col0 letter: a match attempt that OVER must ignore
        for (int k = 0; k < 40; k++) begin
            step();
            if (cor0 != 3'b000) check("over_cor", 32'(cor0), 32'd0);
        end
        check("over_y0", 32'(ypos0[4:0]), 32'd29);
        check("over_act", 32'(act0), 32'b111);
        check("over_l0", 32'(letter0[7:0]), 32'hE1);
        check("over_score", 32'(score0), 32'd0);
        check("over_go", 32'(go0), 32'd1);
        start0 = 1'b1; step(); start0 = 1'b0;
        check("restart_go", 32'(go0), 32'd0);
        check("restart_score", 32'(score0), 32'd0);
        check("restart_act", 32'(act0), 32'b001);
        check("restart_y0", 32'(ypos0[4:0]), 32'd0);
        check("restart_l0", 32'(letter0[7:0] != 8'hE1), 32'd1);

        // Test 5: score to 8, level 1 period, then saturation and level cap
        exp_score = 0; prev_score = 0; sat_clears = 0;
        for (int phase = 0; phase < 2; phase++) begin
            for (int k = 0; k < 20000; k++) begin
                if (phase == 0 && exp_score >= 8) break;
                if (phase == 1 && sat_clears >= 2) break;
                pick = -1;
                for (int i = 0; i < 3; i++) if (act0[i] && pick < 0) pick = i;
                mask = 3'b000;
                if (pick >= 0) begin
                    ui0 = letter0[pick*8 +: 8];
                    for (int i = 0; i < 3; i++) if (act0[i] && letter0[i*8 +: 8] == ui0) mask[i] = 1'b1;
                end
                step();
                check("run_cor", 32'(cor0), 32'(mask));
                if (mask != 3'b000 && exp_score == 255) sat_clears++;
                exp_score = (exp_score + pc(mask) > 255) ? 255 : exp_score + pc(mask);
                check("run_score", 32'(score0), 32'(exp_score));
                check("run_level", 32'(lvl0), 32'(lvl_of(prev_score)));
                prev_score = exp_score;
            end
            if (phase == 0) begin
                v = 8'h00;
                for (int t = 0; t < 4; t++) begin
                    hit = 1'b0;
                    for (int i = 0; i < 3; i++) if (act0[i] && letter0[i*8 +: 8] == v) hit = 1'b1;
                    if (hit) v = v + 8'd1;
                end
                ui0 = v;
                step();
                check("lvl_after8", 32'(lvl0), 32'd1);
                col = -1; c1 = -1; c2 = -1;
                for (int k = 0; k < 100 && col < 0; k++) begin
                    for (int i = 0; i < 3; i++) if (act0[i] && col < 0) col = i;
                    if (col < 0) step();
                end
                if (col >= 0) begin
                    yp = ypos0[col*5 +: 5];
                    for (int k = 0; k < 200 && c2 < 0; k++) begin
                        step();
                        if (ypos0[col*5 +: 5] != yp) begin
                            yp = ypos0[col*5 +: 5];
                            if (c1 < 0) c1 = k;
                            else c2 = k;
                        end
                    end
                end
                check("lvl1_period", 32'(c2 - c1), 32'd8);
                prev_score = exp_score;
            end
        end
        check("sat_reached", 32'(sat_clears >= 2), 32'd1);
        check("sat_score", 32'(score0), 32'd255);
        check("level_cap", 32'(lvl0), 32'd5);
        check("run_go", 32'(go0), 32'd0);

        // Test 6: submit-gated compare with two columns sharing a letter
        rst0 = 1'b1;
        rst1 = 1'b0; ui1 = 2'd0; submit1 = 1'b0;
        start1 = 1'b1; step(); start1 = 1'b0;
        found = 0;
        for (int k = 0; k < 20000 && found == 0; k++) begin
            if (go1) begin
                start1 = 1'b1; step(); start1 = 1'b0;
            end else begin
                v1 = 2'd0;
                for (int i = 0; i < 3; i++)
                    for (int j = i + 1; j < 3; j++)
                        if (found == 0 && act1[i] && act1[j] && letter1[i*2 +: 2] == letter1[j*2 +: 2] &&
                            ypos1[i*5 +: 5] < 5'd20 && ypos1[j*5 +: 5] < 5'd20) begin
                            found = 1;
                            v1 = letter1[i*2 +: 2];
                        end
                if (found != 0) begin
                    mask = 3'b000;
                    for (int i = 0; i < 3; i++) if (act1[i] && letter1[i*2 +: 2] == v1) mask[i] = 1'b1;
                    ui1 = v1;
                    for (int r = 0; r < 3; r++) begin
                        step();
                        check("nosub_cor", 32'(cor1), 32'd0);
                    end
                    check("nosub_act", 32'(act1 & mask), 32'(mask));
                    check("nosub_score", 32'(score1), 32'd0);
                    submit1 = 1'b1; step(); submit1 = 1'b0;
                    check("sub_cor", 32'(cor1), 32'(mask));
                    check("sub_score", 32'(score1), 32'(pc(mask)));
                    check("sub_act", 32'(act1 & mask), 32'd0);
                    step();
                    check("sub_cor_pulse", 32'(cor1), 32'd0);
                end else begin
                    step();
                end
            end
        end
        check("pair_found", 32'(found), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
